// File: rtl/step_sequencer_ctrl_pkg.sv
// Shared widths, reset defaults, state encoding and config payload for the
// step sequencer controller.
package step_sequencer_ctrl_pkg;

  localparam int unsigned STEP_W = 4;
  localparam int unsigned DIV_W  = 27;

  // Power-on configuration: 8 steps, 0.5 s per tick at 100 MHz.
  localparam logic [STEP_W-1:0] DEFAULT_STEPS = 4'd8;
  localparam logic [DIV_W-1:0]  DEFAULT_DIV   = 27'd50000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // One step/rate request as held in the pending slot.
  typedef struct packed {
    logic [STEP_W-1:0] steps;
    logic [DIV_W-1:0]  div;
  } cfg_t;

  // Prescaler reload value: div cycles per tick, with div==0 behaving as 1.
  function automatic logic [DIV_W-1:0] reload_val(input logic [DIV_W-1:0] div);
    return (div == '0) ? '0 : div - DIV_W'(1);
  endfunction

endpackage

// File: rtl/step_sequencer_ctrl_if.sv
// Config handshake between the config source (master) and the controller (slave).
interface step_sequencer_ctrl_if;
  import step_sequencer_ctrl_pkg::*;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [STEP_W-1:0] cfg_steps;
  logic [DIV_W-1:0]  cfg_div;

  modport master (
    output cfg_valid,
    output cfg_steps,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_steps,
    input  cfg_div,
    output cfg_ready
  );

endinterface

// File: rtl/step_sequencer_ctrl_tick_prescaler.sv
// Down-counting tick prescaler. expire_c flags the enabled cycle on which the
// count sits at zero; the owner registers it into the tick output.
module step_sequencer_ctrl_tick_prescaler
  import step_sequencer_ctrl_pkg::*;
#(
  parameter logic [DIV_W-1:0] DEF_DIV = DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             expire_c
);

  logic [DIV_W-1:0] cnt;

  assign expire_c = en & (cnt == '0);

  // Reload on request or on expiry; otherwise count down while enabled, hold when not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= reload_val(DEF_DIV);
    end else if (load || expire_c) begin
      cnt <= reload_val(div);
    end else if (en) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/step_sequencer_ctrl.sv
// Run/pause/single-step controller for the 4-bit step counter. Generates the
// counter tick from a programmable prescaler, owns the active step limit and
// takes new step/rate settings over a valid/ready slot. While running, a new
// step limit waits for a wrap so a sequence is never cut short.
module step_sequencer_ctrl
  import step_sequencer_ctrl_pkg::*;
#(
  parameter logic [STEP_W-1:0] DEF_STEPS = DEFAULT_STEPS,
  parameter logic [DIV_W-1:0]  DEF_DIV   = DEFAULT_DIV
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_run,
  input  logic                btn_step,
  input  logic                btn_clear,
  step_sequencer_ctrl_if.slave cfg,
  input  logic [STEP_W-1:0]   count_i,
  output logic                tick,
  output logic [STEP_W-1:0]   steps,
  output logic                ctr_clr,
  output logic                running,
  output logic                wrap
);

  state_t           state;
  logic [DIV_W-1:0] div;
  cfg_t             pend;
  logic             pend_valid;
  logic             cfg_ready_q;

  logic             wrap_c;
  logic             accept_c;
  logic             apply_c;
  logic [DIV_W-1:0] eff_div_c;
  logic             load_c;
  logic             en_c;
  logic             step_c;
  logic             expire_c;

  assign cfg.cfg_ready = cfg_ready_q;

  // Per-cycle decisions; btn_clear outranks btn_run, which outranks btn_step.
  always_comb begin
    wrap_c    = tick & (count_i >= steps) & (steps != '0);
    accept_c  = cfg.cfg_valid & cfg_ready_q;
    // In RUN a pending config lands only on the tick that wraps the counter
    // (or any tick when the limit is 0); elsewhere it lands immediately.
    apply_c   = pend_valid &
                (btn_clear | (state != ST_RUN) | (tick & (wrap_c | (steps == '0))));
    eff_div_c = apply_c ? pend.div : div;
    load_c    = btn_clear | (btn_run & (state == ST_IDLE));
    en_c      = (state == ST_RUN) & ~btn_clear & ~btn_run;
    step_c    = btn_step & ~btn_clear & ~btn_run & (state != ST_RUN);
  end

  step_sequencer_ctrl_tick_prescaler #(
    .DEF_DIV (DEF_DIV)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .en       (en_c),
    .div      (eff_div_c),
    .expire_c (expire_c)
  );

  // Run/pause/idle state machine with registered running flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else if (btn_clear) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else if (btn_run) begin
      case (state)
        ST_IDLE, ST_PAUSE: begin
          state   <= ST_RUN;
          running <= 1'b1;
        end
        ST_RUN: begin
          state   <= ST_PAUSE;
          running <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  // One-cycle pulses to the step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick    <= 1'b0;
      wrap    <= 1'b0;
      ctr_clr <= 1'b0;
    end else begin
      tick    <= expire_c | step_c;
      wrap    <= wrap_c;
      ctr_clr <= btn_clear;
    end
  end

  // Active configuration and the single-entry pending slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      steps       <= DEF_STEPS;
      div         <= DEF_DIV;
      pend        <= '0;
      pend_valid  <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      if (apply_c) begin
        steps <= pend.steps;
        div   <= pend.div;
      end
      if (accept_c) begin
        pend <= {cfg.cfg_steps, cfg.cfg_div};
      end
      pend_valid  <= accept_c | (pend_valid & ~apply_c);
      cfg_ready_q <= ~(accept_c | (pend_valid & ~apply_c));
    end
  end

endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// Bench for step_sequencer_ctrl: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the controller and
// a model of the step counter that drives count_i.
module tb_step_sequencer_ctrl;
  import step_sequencer_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              btn_run = 1'b0;
  logic              btn_step = 1'b0;
  logic              btn_clear = 1'b0;
  logic [STEP_W-1:0] count_i;
  logic              tick;
  logic [STEP_W-1:0] steps;
  logic              ctr_clr;
  logic              running;
  logic              wrap;

  step_sequencer_ctrl_if cfg_if ();

  step_sequencer_ctrl #(
    .DEF_STEPS (4'd8),
    .DEF_DIV   (27'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_run   (btn_run),
    .btn_step  (btn_step),
    .btn_clear (btn_clear),
    .cfg       (cfg_if),
    .count_i   (count_i),
    .tick      (tick),
    .steps     (steps),
    .ctr_clr   (ctr_clr),
    .running   (running),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: mode 0=idle 1=run 2=pause; left = run cycles until the next tick.
  int m_mode, m_left, m_steps, m_div, m_pst, m_pdiv, cnt;
  bit m_pend, e_tick, e_wrap, e_clr, e_run, e_ready;

  assign count_i = STEP_W'(cnt);

  function automatic logic [8:0] dut_vec();
    return {tick, wrap, ctr_clr, running, cfg_if.cfg_ready, steps};
  endfunction

  function automatic logic [8:0] exp_vec();
    return {e_tick, e_wrap, e_clr, e_run, e_ready, STEP_W'(m_steps)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = 4; m_steps = 8; m_div = 4;
    m_pend = 1'b0; m_pst = 0; m_pdiv = 0; cnt = 0;
    e_tick = 1'b0; e_wrap = 1'b0; e_clr = 1'b0; e_run = 1'b0; e_ready = 1'b1;
  endtask

  // Advance the model by one clock using the inputs that were applied to the DUT.
  task automatic model_step();
    bit wrap_now, accept, apply, tk;
    int per;
    wrap_now = e_tick && (cnt >= m_steps) && (m_steps != 0);
    accept   = cfg_if.cfg_valid && e_ready;
    apply    = m_pend && (btn_clear || m_mode != 1 || (e_tick && (wrap_now || m_steps == 0)));
    // step counter: cleared by ctr_clr, wraps after reaching the limit
    if (e_clr) cnt = 0;
    else if (e_tick) cnt = (cnt >= m_steps) ? 0 : cnt + 1;
    if (apply) begin
      m_steps = m_pst; m_div = m_pdiv; m_pend = 1'b0;
    end
    per = (m_div == 0) ? 1 : m_div;
    tk = 1'b0;
    if (btn_clear) begin
      m_mode = 0; m_left = per;
    end else if (btn_run) begin
      if (m_mode == 0) begin m_mode = 1; m_left = per; end
      else if (m_mode == 1) m_mode = 2;
      else m_mode = 1;
    end else if (btn_step && m_mode != 1) begin
      tk = 1'b1;
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) begin tk = 1'b1; m_left = per; end
    end
    if (accept) begin
      m_pend = 1'b1; m_pst = int'(cfg_if.cfg_steps); m_pdiv = int'(cfg_if.cfg_div);
    end
    e_tick = tk; e_wrap = wrap_now; e_clr = btn_clear;
    e_run = (m_mode == 1); e_ready = !m_pend;
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
    model_step();
    cyc++;
  endtask

  task automatic test_reset();
    btn_run = 1'b0; btn_step = 1'b0; btn_clear = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_steps = '0; cfg_if.cfg_div = '0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_state got=%b exp=%b", dut_vec(), exp_vec());
    end
    checks++;
    if (steps !== 4'd8 || cfg_if.cfg_ready !== 1'b1 || running !== 1'b0 || tick !== 1'b0) begin
      failures++; $display("FAIL reset_const steps=%0d ready=%b running=%b tick=%b exp 8/1/0/0",
                           steps, cfg_if.cfg_ready, running, tick);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      tick_clk();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_run_ticks();
    int first, nticks, nwrap, wrap_at;
    first = -1; nticks = 0; nwrap = 0; wrap_at = -1;
    btn_run = 1'b1; tick_clk(); btn_run = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick_clk();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL run_ticks cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
      if (tick === 1'b1) begin nticks++; if (first < 0) first = n; end
      if (wrap === 1'b1) begin nwrap++; wrap_at = n; end
    end
    checks++;
    if (first != 4 || nticks != 10) begin
      failures++; $display("FAIL run_tick_rate first=%0d count=%0d exp 4/10", first, nticks);
    end
    checks++;
    if (nwrap != 1 || wrap_at != 37 || steps !== 4'd8) begin
      failures++; $display("FAIL run_wrap wraps=%0d at=%0d steps=%0d exp 1/37/8", nwrap, wrap_at, steps);
    end
  endtask

  task automatic test_pause();
    int nt;
    nt = 0;
    btn_clear = 1'b1; tick_clk(); btn_clear = 1'b0;
    btn_run = 1'b1; tick_clk(); btn_run = 1'b0;
    repeat (2) tick_clk();
    btn_run = 1'b1; tick_clk(); btn_run = 1'b0;
    checks++;
    if (dut_vec() !== exp_vec() || running !== 1'b0) begin
      failures++; $display("FAIL pause_enter got=%b exp=%b", dut_vec(), exp_vec());
    end
    repeat (10) begin
      tick_clk();
      if (tick === 1'b1) nt++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL pause_hold cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (nt != 0) begin
      failures++; $display("FAIL pause_no_ticks got=%0d exp=0", nt);
    end
    btn_run = 1'b1; tick_clk(); btn_run = 1'b0;
    tick_clk();
    checks++;
    if (tick !== 1'b0 || running !== 1'b1) begin
      failures++; $display("FAIL resume_early tick=%b running=%b exp 0/1", tick, running);
    end
    tick_clk();
    checks++;
    if (tick !== 1'b1 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL resume_tick tick=%b got=%b exp=%b", tick, dut_vec(), exp_vec());
    end
  endtask

  task automatic test_step();
    int nt;
    nt = 0;
    btn_run = 1'b1; tick_clk(); btn_run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      btn_step = 1'b1; tick_clk(); btn_step = 1'b0;
      if (tick === 1'b1) nt++;
      checks++;
      if (tick !== 1'b1 || dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL step_tick i=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      repeat (2) begin
        tick_clk();
        if (tick === 1'b1) nt++;
      end
    end
    checks++;
    if (nt != 3) begin
      failures++; $display("FAIL step_count got=%0d exp=3", nt);
    end
    btn_clear = 1'b1; tick_clk(); btn_clear = 1'b0;
    btn_run = 1'b1; tick_clk(); btn_run = 1'b0;
    btn_step = 1'b1; tick_clk(); btn_step = 1'b0;
    nt = (tick === 1'b1) ? 1 : 0;
    repeat (2) begin
      tick_clk();
      if (tick === 1'b1) nt++;
    end
    checks++;
    if (nt != 0) begin
      failures++; $display("FAIL step_in_run extra_ticks=%0d exp=0", nt);
    end
    tick_clk();
    checks++;
    if (tick !== 1'b1 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL step_run_resume got=%b exp=%b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_cfg_deferred();
    bit found;
    int nwrap;
    btn_clear = 1'b1; tick_clk(); btn_clear = 1'b0;
    btn_run = 1'b1; tick_clk(); btn_run = 1'b0;
    for (int n = 0; n < 100 && count_i != 4'd3; n++) tick_clk();
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_steps = 4'd2; cfg_if.cfg_div = 27'd4;
    tick_clk();
    cfg_if.cfg_valid = 1'b0;
    checks++;
    if (cfg_if.cfg_ready !== 1'b0 || steps !== 4'd8 || count_i !== 4'd3) begin
      failures++; $display("FAIL cfg_accept ready=%b steps=%0d count=%0d exp 0/8/3",
                           cfg_if.cfg_ready, steps, count_i);
    end
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      tick_clk();
      checks++;
      if (wrap === 1'b1) begin
        found = 1'b1;
        if (steps !== 4'd2 || cfg_if.cfg_ready !== 1'b1 || dut_vec() !== exp_vec()) begin
          failures++; $display("FAIL cfg_apply steps=%0d ready=%b exp 2/1", steps, cfg_if.cfg_ready);
        end
      end else if (steps !== 4'd8 || cfg_if.cfg_ready !== 1'b0) begin
        failures++; $display("FAIL cfg_deferred steps=%0d ready=%b exp 8/0", steps, cfg_if.cfg_ready);
      end
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL cfg_wrap_timeout wrap=%b exp a wrap within 100 cycles", wrap);
    end
    nwrap = 0;
    repeat (24) begin
      tick_clk();
      if (wrap === 1'b1) nwrap++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL cfg_new_limit cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (nwrap != 2) begin
      failures++; $display("FAIL cfg_wrap_count got=%0d exp=2", nwrap);
    end
  endtask

  task automatic test_clear_priority();
    btn_clear = 1'b1; btn_run = 1'b1; btn_step = 1'b1;
    tick_clk();
    btn_clear = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
    checks++;
    if (running !== 1'b0 || ctr_clr !== 1'b1 || tick !== 1'b0) begin
      failures++; $display("FAIL clear_prio running=%b ctr_clr=%b tick=%b exp 0/1/0", running, ctr_clr, tick);
    end
    tick_clk();
    checks++;
    if (ctr_clr !== 1'b0 || running !== 1'b0 || tick !== 1'b0 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL clear_after got=%b exp=%b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_div_zero();
    int nt;
    bit found;
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_steps = 4'd8; cfg_if.cfg_div = 27'd0;
    tick_clk();
    cfg_if.cfg_valid = 1'b0;
    tick_clk();
    checks++;
    if (cfg_if.cfg_ready !== 1'b1 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL div0_apply got=%b exp=%b", dut_vec(), exp_vec());
    end
    btn_run = 1'b1; tick_clk(); btn_run = 1'b0;
    nt = 0;
    repeat (12) begin
      tick_clk();
      if (tick === 1'b1) nt++;
    end
    checks++;
    if (nt != 12) begin
      failures++; $display("FAIL div0_rate ticks=%0d exp=12", nt);
    end
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_steps = 4'd0; cfg_if.cfg_div = 27'd0;
    tick_clk();
    cfg_if.cfg_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      tick_clk();
      if (wrap === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || steps !== 4'd0) begin
      failures++; $display("FAIL steps0_apply wrap_seen=%b steps=%0d exp 1/0", found, steps);
    end
    for (int n = 0; n < 20; n++) begin
      tick_clk();
      checks++;
      if (tick !== 1'b1 || wrap !== 1'b0 || count_i !== 4'd0 || dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL steps0_run n=%0d tick=%b wrap=%b count=%0d exp 1/0/0", n, tick, wrap, count_i);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      btn_clear = (r < 2);
      btn_run   = (r >= 2 && r < 7);
      btn_step  = ($urandom_range(0, 19) == 0);
      cfg_if.cfg_valid = ($urandom_range(0, 9) == 0);
      cfg_if.cfg_steps = STEP_W'($urandom_range(0, 15));
      cfg_if.cfg_div   = DIV_W'($urandom_range(0, 5));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== exp_vec()) begin
          failures++; $display("FAIL mid_reset cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
        end
        @(negedge clk);
        rst = 1'b0;
      end else begin
        tick_clk();
        checks++;
        if (dut_vec() !== exp_vec()) begin
          failures++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
        end
      end
    end
    btn_clear = 1'b0; btn_run = 1'b0; btn_step = 1'b0; cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_ticks();
    test_pause();
    test_step();
    test_cfg_deferred();
    test_clear_priority();
    test_div_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d exp completion before time limit", cyc);
    $fatal(1, "timeout");
  end

endmodule
